// File: rtl/block_fill_server.sv
// Memory-side block fill server: assembles 2**BLOCK_SIZE-word blocks for cache
// misses from word-wide synchronous memory and commits write-through stores.
module block_fill_server #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    input  logic                                   req_we,
    input  logic [ADDRESS_WIDTH-1:0]               req_addr,
    input  logic [DATA_WIDTH-1:0]                  req_wdata,
    output logic                                   req_ready,
    output logic                                   resp_valid,
    output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0]  resp_block,
    output logic [ADDRESS_WIDTH-1:0]               resp_addr,
    output logic                                   wr_done,
    output logic [ADDRESS_WIDTH-1:0]               mem_addr,
    output logic                                   mem_re,
    output logic                                   mem_we,
    output logic [DATA_WIDTH-1:0]                  mem_wdata,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata
);

    localparam int N  = 2**BLOCK_SIZE;
    localparam int BW = DATA_WIDTH*N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_RESP,
        S_WRITE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [BLOCK_SIZE-1:0]     r_beat;
    logic [BW-1:0]             r_slots;
    logic [BW-1:0]             r_resp_block;
    logic [ADDRESS_WIDTH-1:0]  r_resp_addr;
    logic [BW-1:0]             w_fill;
    logic [BLOCK_SIZE-1:0]     w_idx;
    logic                      w_accept;
    logic                      w_cap;

    assign w_accept = req_valid && (r_state == S_IDLE);
    // Read data trails the issued beat by one cycle, so slot = beat - 1.
    assign w_idx    = r_beat - 1'b1;
    assign w_cap    = ((r_state == S_FETCH) && (r_beat != '0)) ||
                      (r_state == S_LAST);

    always_comb begin
        w_fill = r_slots;
        w_fill[(N-1)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = req_we ? S_WRITE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (&r_beat) begin
                    w_next = S_LAST;
                end
            end
            S_LAST:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        wr_done    = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_FETCH: begin
                mem_re   = 1'b1;
                mem_addr = {r_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], r_beat};
            end
            S_RESP: resp_valid = 1'b1;
            S_WRITE: begin
                mem_we    = 1'b1;
                wr_done   = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_beat       <= '0;
            r_slots      <= '0;
            r_resp_block <= '0;
            r_resp_addr  <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_beat  <= '0;
            end
            if (r_state == S_FETCH) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_cap) begin
                r_slots[w_idx*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            end
            if (r_state == S_LAST) begin
                r_resp_block <= w_fill;
                r_resp_addr  <= {r_addr[ADDRESS_WIDTH-1:BLOCK_SIZE],
                                 {BLOCK_SIZE{1'b0}}};
            end
        end
    end

    assign resp_block = r_resp_block;
    assign resp_addr  = r_resp_addr;

endmodule

// File: tb/tb_block_fill_server.sv
// Testbench for block_fill_server: directed table, corner sequences and
// randomized reads/writes against a word-array model of main memory.
module tb_block_fill_server;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int BS = 3;
    localparam int N  = 8;
    localparam int BW = DW*N;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready;
    logic          resp_valid;
    logic [BW-1:0] resp_block;
    logic [AW-1:0] resp_addr;
    logic          wr_done;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] tbmem     [logic [AW-1:0]];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [BW-1:0] last_blk;

    block_fill_server #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .BLOCK_SIZE   (BS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_block(resp_block),
        .resp_addr (resp_addr),
        .wr_done   (wr_done),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: unwritten word a holds value a.
    always @(posedge clk) begin
        if (mem_we) tbmem[mem_addr] = mem_wdata;
        if (mem_re) begin
            if (tbmem.exists(mem_addr)) mem_rdata <= tbmem[mem_addr];
            else mem_rdata <= {{(DW-AW){1'b0}}, mem_addr};
        end
    end

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return {{(DW-AW){1'b0}}, a};
    endfunction

    function automatic logic [BW-1:0] model_blk(input logic [AW-1:0] a);
        logic [BW-1:0] b;
        logic [AW-1:0] base;
        base = (a / N) * N;
        b = '0;
        for (int k = 0; k < N; k++) b[k*DW +: DW] = model_rd(base + AW'(k));
        return b;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        logic [AW-1:0] base;
        logic [BW-1:0] exp;
        base = (a / N) * N;
        exp  = model_blk(a);
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_wdata = $urandom;
        for (int c = 1; c <= N+3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_addr  = AW'($urandom);
                chk("rd_hold_blk", resp_block, last_blk);
            end
            chk("rd_re", mem_re, (c <= N) ? 1 : 0);
            chk("rd_we", mem_we, 0);
            chk("rd_valid", resp_valid, (c == N+2) ? 1 : 0);
            chk("rd_ready", req_ready, (c == N+3) ? 1 : 0);
            if (c <= N) chk("rd_addr", mem_addr, base + AW'(c-1));
            if (c == N+2) begin
                chk("rd_base", resp_addr, base);
                chk("rd_block", resp_block, exp);
            end
        end
        last_blk = exp;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        chk("wr_we", mem_we, 1);
        chk("wr_re", mem_re, 0);
        chk("wr_done", wr_done, 1);
        chk("wr_addr", mem_addr, a);
        chk("wr_data", mem_wdata, d);
        chk("wr_ready1", req_ready, 0);
        chk("wr_rv", resp_valid, 0);
        @(negedge clk);
        chk("wr_ready2", req_ready, 1);
        chk("wr_strobe_off", {mem_we, wr_done}, 0);
        chk("wr_hold_blk", resp_block, last_blk);
        model_mem[a] = d;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] exp_base;
        int            exp_idx;
        logic [DW-1:0] exp_word;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n_acc, acc2, nresp, r1, r2, bad;
        logic [AW-1:0] ra;

        tbl[0] = '{1'b0, 30'h13, 32'h0, 30'h10, 3, 32'h13};
        tbl[1] = '{1'b1, 30'h25, 32'hDEADBEEF, 30'h0, 0, 32'h0};
        tbl[2] = '{1'b0, 30'h20, 32'h0, 30'h20, 5, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 30'h3FFFFFFF, 32'h0, 30'h3FFFFFF8, 0, 32'h3FFFFFF8};
        tbl[4] = '{1'b0, 30'h3FFFFFFF, 32'h0, 30'h3FFFFFF8, 7, 32'h3FFFFFFF};

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        last_blk = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset pulse while idle
        rst = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_strobes", {resp_valid, wr_done, mem_re, mem_we}, 0);
        chk("rst_block", resp_block, 0);
        chk("rst_addrs", {resp_addr, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", req_ready, 1);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].we) begin
                do_write(tbl[i].addr, tbl[i].wdata);
            end else begin
                do_read(tbl[i].addr);
                chk("tbl_base", resp_addr, tbl[i].exp_base);
                chk("tbl_word", resp_block[tbl[i].exp_idx*DW +: DW],
                    tbl[i].exp_word);
            end
        end

        // req_valid held high across two back-to-back fills
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 30'h50;
        n_acc = 0; acc2 = -1; nresp = 0; r1 = -1; r2 = -1;
        for (int t = 0; t <= 21; t++) begin
            if (t > 0) @(negedge clk);
            if (req_ready) begin
                n_acc++;
                if (n_acc == 2) acc2 = t;
            end
            if (resp_valid) begin
                nresp++;
                if (nresp == 1) r1 = t;
                else r2 = t;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_accepts", n_acc, 2);
        chk("hold_acc2", acc2, 11);
        chk("hold_nresp", nresp, 2);
        chk("hold_r1", r1, 10);
        chk("hold_r2", r2, 21);
        last_blk = model_blk(30'h50);
        chk("hold_block", resp_block, last_blk);

        // Reset in cycle 4 of a fill
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 30'h88;
        repeat (4) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("abort_re", mem_re, 0);
        chk("abort_rv", resp_valid, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_block", resp_block, 0);
        @(negedge clk);
        rst = 1'b0;
        last_blk = '0;
        bad = 0;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (resp_valid || wr_done || mem_re || mem_we) bad++;
        end
        chk("abort_quiet", bad, 0);
        do_read(30'h40);
        chk("abort_reread", resp_addr, 30'h40);

        // Random mix against the memory model
        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                             : AW'($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) do_write(ra, $urandom);
            else do_read(ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
